vga_background_fetch: RTL
=========================

Name: vga_background_fetch

Overview:
- Line-prefetch stage directly upstream of the background pixel shifters.
- During horizontal blanking it reads two 32-bit background words (16 two-bit colour indices each) for the next line from a word-addressed memory port. It presents them on a shared bg_pixels bus with per-shifter load strobes: word 0 goes to shifter 0, word 1 to shifter 1.
- It flags an underrun if memory does not answer before the active region starts.

Parameters:
- ADDR_W, 16, width of the memory word address.
- LINE_W, 9, width of the line index input.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- h_counter  in  10  current horizontal pixel counter from VGA timing.
- h_active_start  in  10  first active pixel of a line.
- h_active_end  in  10  first blank pixel after the active region.
- fetch_enable  in  1  the next line is active (vertical window); sampled at trigger.
- line_index  in  LINE_W  background row for the next line; sampled at trigger.
- bg_base  in  ADDR_W  word address of row 0.
- mem_req  out  1  read request; held until acknowledged.
- mem_addr  out  ADDR_W  word address; stable while mem_req=1.
- mem_ack  in  1  single-cycle acknowledge; mem_rdata valid in the same cycle.
- mem_rdata  in  32  read data.
- bg_pixels  out  32  data bus to both shifters.
- bg_pixels_load_0  out  1  one-cycle load strobe for shifter 0.
- bg_pixels_load_1  out  1  one-cycle load strobe for shifter 1.
- busy  out  1  fetch in progress.
- underrun  out  1  sticky missed-deadline flag.
- underrun_clear  in  1  clears underrun.

Behaviour:
- Reset values: mem_req=0, mem_addr=0, bg_pixels=0, both loads=0, busy=0, underrun=0, FSM=IDLE. Reset mid-fetch drops mem_req in the next cycle with no handshake completion; an ack arriving during reset is ignored.
- Trigger condition: state IDLE, h_counter==h_active_end and fetch_enable=1. On trigger, latch row_addr = bg_base + {line_index,1'b0}, truncated modulo 2^ADDR_W. Wrap-around is allowed.
- FSM states: IDLE, REQ0, REQ1.
  - IDLE -> REQ0 on trigger. In the same edge: mem_req<=1, mem_addr<=row_addr.
  - REQ0 with mem_ack: bg_pixels<=mem_rdata, load_0<=1 for the next cycle only, mem_addr<=row_addr+1 (mod 2^ADDR_W), mem_req stays 1 -> REQ1.
  - REQ1 with mem_ack: bg_pixels<=mem_rdata, load_1<=1 for the next cycle only, mem_req<=0 -> IDLE.
- Latency:
  - Load strobe is asserted exactly one cycle after its ack, with bg_pixels carrying that word in the same cycle.
  - mem_req is high from the cycle after the trigger through the cycle of the second ack.
  - With zero-wait acks the fetch occupies 3 cycles.
- Handshake rules: mem_addr never changes while mem_req=1 except on an ack edge. An ack while mem_req=0 is ignored.
- Deadline: if the FSM is in REQ0 or REQ1 and h_counter==h_active_start without an ack in that cycle:
  - abort to IDLE and drop mem_req;
  - issue no further load strobes;
  - set underrun<=1.
  - Shifters keep their previous contents.
  - An ack in the deadline cycle itself completes normally.
- underrun_clear in the same cycle as a new underrun leaves underrun=1 (set wins).
- A trigger condition while not IDLE is ignored.
- fetch_enable=0 at trigger: no request, no strobes.
- load_0 and load_1 are never high in the same cycle.
- busy = (state != IDLE), combinational from the state register.

Decomposition:
- Shared VGA package:
  - FSM state encoding (IDLE/REQ0/REQ1).
  - BG_WORDS_PER_LINE=2.
  - BG_PIXEL_BITS=2.
  - 32-bit pixel-word width constant, also used by the shifter block.
- No sub-module. The FSM, address register and output registers form a single flat module.

Test Plan:
- Zero-wait memory, bg_base=0x0100, line_index=3, trigger at h_counter==h_active_end=640 -> mem_addr 0x0106 then 0x0107. Load strobes at cycles +2 and +3 after the trigger edge, bg_pixels=0xA5A5_0F0F then 0x1234_5678. busy low after the second load.
- Acks delayed 5 cycles each -> mem_req stays high and mem_addr stays stable while waiting. Each strobe follows its ack by exactly 1 cycle. No underrun.
- Memory never acks the second word and h_counter reaches h_active_start=0 -> underrun=1, mem_req=0, load_0 pulsed once, load_1 never pulses. underrun_clear then returns underrun to 0.
- fetch_enable=0 at the trigger -> mem_req, both loads and busy stay 0 for the whole line.
- bg_base=0xFFFE, line_index=0 -> addresses 0xFFFE then 0xFFFF. Then bg_base=0xFFFF, line_index=0 -> addresses 0xFFFF then 0x0000 (wraps).
- reset asserted while in REQ1 with an ack in the same cycle -> next cycle mem_req=0, no load_1 strobe, underrun=0, FSM IDLE. The next trigger fetches normally.

Source files
------------

// File: rtl/vga_background_fetch_pkg.sv
// vga_background_fetch_pkg: shared VGA background constants and fetch FSM encoding
package vga_background_fetch_pkg;
  localparam int BG_WORDS_PER_LINE = 2;
  localparam int BG_PIXEL_BITS     = 2;
  localparam int BG_WORD_W         = 32;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ0, ST_REQ1} bg_fetch_state_t;
endpackage

// File: rtl/vga_background_fetch_if.sv
// vga_background_fetch_if: word-addressed read port between the fetcher (master) and memory (slave)
//   mem_req/mem_addr : request held until acknowledged, address stable meanwhile
//   mem_ack/mem_rdata: single-cycle acknowledge with data in the same cycle
interface vga_background_fetch_if
  import vga_background_fetch_pkg::*;
#(
  parameter int ADDR_W = 16
);
  logic                 mem_req;
  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_ack;
  logic [BG_WORD_W-1:0] mem_rdata;
  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/vga_background_fetch.sv
// vga_background_fetch: prefetches two background words per line during hblank and strobes them into the shifters
//   clk, reset (sync, active-high)
//   h_counter/h_active_start/h_active_end : horizontal timing
//   fetch_enable, line_index, bg_base     : sampled when the fetch triggers at h_active_end
//   mem                                   : memory read port (master side)
//   bg_pixels, bg_pixels_load_0/1         : shared shifter data bus and per-shifter load strobes
//   busy, underrun, underrun_clear        : status; underrun is sticky, a new underrun beats a clear
module vga_background_fetch
  import vga_background_fetch_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            h_counter,
  input  logic [9:0]            h_active_start,
  input  logic [9:0]            h_active_end,
  input  logic                  fetch_enable,
  input  logic [LINE_W-1:0]     line_index,
  input  logic [ADDR_W-1:0]     bg_base,
  vga_background_fetch_if.master mem,
  output logic [BG_WORD_W-1:0]  bg_pixels,
  output logic                  bg_pixels_load_0,
  output logic                  bg_pixels_load_1,
  output logic                  busy,
  output logic                  underrun,
  input  logic                  underrun_clear
);
  bg_fetch_state_t      state, state_n;
  logic                 req_n, l0_n, l1_n, und_n;
  logic [ADDR_W-1:0]    addr_n, row_addr;
  logic [BG_WORD_W-1:0] pix_n;
  logic                 deadline;
  // each background row spans BG_WORDS_PER_LINE consecutive words; address math wraps
  assign row_addr = bg_base + ADDR_W'({line_index, 1'b0});
  assign deadline = h_counter == h_active_start;
  assign busy     = state != ST_IDLE;
  always_comb begin
    state_n = state;
    req_n   = mem.mem_req;
    addr_n  = mem.mem_addr;
    pix_n   = bg_pixels;
    l0_n    = 1'b0;
    l1_n    = 1'b0;
    und_n   = underrun & ~underrun_clear;
    case (state)
      ST_IDLE: if (h_counter == h_active_end && fetch_enable) begin
        state_n = ST_REQ0;
        req_n   = 1'b1;
        addr_n  = row_addr;
      end
      ST_REQ0: if (mem.mem_ack) begin
        state_n = ST_REQ1;
        pix_n   = mem.mem_rdata;
        l0_n    = 1'b1;
        addr_n  = mem.mem_addr + ADDR_W'(1);
      end else if (deadline) begin
        state_n = ST_IDLE;
        req_n   = 1'b0;
        und_n   = 1'b1;
      end
      ST_REQ1: if (mem.mem_ack) begin
        state_n = ST_IDLE;
        pix_n   = mem.mem_rdata;
        l1_n    = 1'b1;
        req_n   = 1'b0;
      end else if (deadline) begin
        state_n = ST_IDLE;
        req_n   = 1'b0;
        und_n   = 1'b1;
      end
      default: begin
        state_n = ST_IDLE;
        req_n   = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      mem.mem_req      <= 1'b0;
      mem.mem_addr     <= '0;
      bg_pixels        <= '0;
      bg_pixels_load_0 <= 1'b0;
      bg_pixels_load_1 <= 1'b0;
      underrun         <= 1'b0;
    end else begin
      state            <= state_n;
      mem.mem_req      <= req_n;
      mem.mem_addr     <= addr_n;
      bg_pixels        <= pix_n;
      bg_pixels_load_0 <= l0_n;
      bg_pixels_load_1 <= l1_n;
      underrun         <= und_n;
    end
  end
endmodule
